// File: rtl/tt_um_alberto_counter_mux7seg.sv
// rtl/tt_um_alberto_counter_mux7seg.sv - up/down modulo counter with BCD/hex multiplexed 7-segment display
// Counter -> sequential double-dabble -> atomic display register -> scanned, blanked segment output.
module tt_um_alberto_counter_mux7seg #(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255,
   parameter int TICK_DIV  = 4,
   parameter int SCAN_DIV  = 4,
   parameter int NDIG      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int BCW = $clog2(WIDTH);

   localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
   localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
   localparam logic [SDW-1:0]   SDIV_LAST = SDW'(SCAN_DIV - 1);
   localparam logic [SDW-1:0]   SDIV_ONE  = SDW'(1);
   localparam logic [SW-1:0]    SCAN_LAST = SW'(NDIG - 1);
   localparam logic [SW-1:0]    SCAN_ONE  = SW'(1);
   localparam logic [BCW-1:0]   BIT_LAST  = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0]   BIT_ONE   = BCW'(1);
   localparam logic [NDIG-1:0]  SEL_ONE   = NDIG'(1);

   localparam logic [1:0] ST_SNAP   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   logic             run, dir, ld, hex, clr, load_edge;
   logic [7:0]       load_raw;
   logic [WIDTH-1:0] load_val;
   logic             unused_ok;

   logic             ld_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             wrap_q, wrap_d;

   logic [1:0]       state_q, state_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [11:0]      bcd_q, bcd_d, adj;
   logic [11:0]      disp_q, disp_d;

   logic [SDW-1:0]   sdiv_q, sdiv_d;
   logic [SW-1:0]    scan_q, scan_d;
   logic [6:0]       seg_q, seg_d;
   logic [NDIG-1:0]  sel_q, sel_d;
   logic [NDIG-1:0]  upper_nz;
   logic [3:0]       cur_dig;
   logic             blank;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   assign run       = ui_in[0];
   assign dir       = ui_in[1];
   assign ld        = ui_in[2];
   assign hex       = ui_in[3];
   assign clr       = ui_in[4];
   assign load_raw  = {uio_in[7:3], ui_in[7:5]};
   assign load_val  = (load_raw[WIDTH-1:0] > MAXV) ? MAXV : load_raw[WIDTH-1:0];
   assign load_edge = ld & ~ld_q;
   assign unused_ok = &{1'b0, uio_in[2:0], load_raw};

   always_comb begin
      cnt_d  = cnt_q;
      pre_d  = pre_q;
      wrap_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         pre_d = '0;
      end else if (load_edge) begin
         cnt_d = load_val;
         pre_d = '0;
      end else if (run && ena) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (!dir) begin
               if (cnt_q == MAXV) begin
                  cnt_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else if (cnt_q == '0) begin
               cnt_d  = MAXV;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end else begin
            pre_d = pre_q + PRE_ONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      bcd_d   = bcd_q;
      disp_d  = disp_q;
      adj     = bcd_q;
      for (int k = 0; k < 3; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
      case (state_q)
         ST_SNAP: begin
            shreg_d = cnt_q;
            bcd_d   = '0;
            bit_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            bcd_d   = {adj[10:0], shreg_q[WIDTH-1]};
            // rotate, so after WIDTH steps shreg again holds the snapped count for hex mode
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            bit_d   = bit_q + BIT_ONE;
            if (bit_q == BIT_LAST) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            disp_d  = hex ? 12'(shreg_q) : bcd_q;
            state_d = ST_SNAP;
         end
         default: state_d = ST_SNAP;
      endcase
   end

   always_comb begin
      sdiv_d = sdiv_q + SDIV_ONE;
      scan_d = scan_q;
      if (sdiv_q == SDIV_LAST) begin
         sdiv_d = '0;
         scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_ONE;
      end
      upper_nz = '0;
      for (int k = 0; k < NDIG; k++) begin
         for (int j = 0; j < NDIG; j++) begin
            if (j >= k && disp_q[4*j +: 4] != 4'd0) upper_nz[k] = 1'b1;
         end
      end
      cur_dig = '0;
      blank   = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         if (scan_q == SW'(k)) begin
            cur_dig = disp_q[4*k +: 4];
            blank   = (k != 0) && !upper_nz[k];
         end
      end
      seg_d = blank ? 7'h00 : seg7(cur_dig);
      sel_d = SEL_ONE << scan_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_q    <= 1'b0;
         cnt_q   <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
         state_q <= ST_SNAP;
         bit_q   <= '0;
         shreg_q <= '0;
         bcd_q   <= '0;
         disp_q  <= '0;
         sdiv_q  <= '0;
         scan_q  <= '0;
         seg_q   <= '0;
         sel_q   <= '0;
      end else begin
         ld_q    <= ld;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         wrap_q  <= wrap_d;
         state_q <= state_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
         disp_q  <= disp_d;
         sdiv_q  <= sdiv_d;
         scan_q  <= scan_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

   assign uo_out  = {wrap_q, seg_q};
   assign uio_out = {{(8-NDIG){1'b0}}, sel_q};
   assign uio_oe  = {{(8-NDIG){1'b0}}, {NDIG{1'b1}}};

endmodule

// File: tb/tb_tt_um_alberto_counter_mux7seg.sv
// tb/tb_tt_um_alberto_counter_mux7seg.sv - randomized bench against a behavioural counter/display model
// Two builds run side by side: default (MAX_COUNT=255) and MAX_COUNT=99.
module tb_tt_um_alberto_counter_mux7seg;

   localparam int W  = 8;
   localparam int TD = 4;
   localparam int SD = 4;
   localparam int ND = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo  [2];
   logic [7:0] uio [2];
   logic [7:0] oe  [2];

   int max_c [2] = '{255, 99};
   int cnt   [2];
   int ph    [2];
   int wrp   [2];
   int prev_ld;
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tt_um_alberto_counter_mux7seg dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo[0]), .uio_out(uio[0]), .uio_oe(oe[0])
   );

   tt_um_alberto_counter_mux7seg #(.MAX_COUNT(99)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo[1]), .uio_out(uio[1]), .uio_oe(oe[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int glyph(input int d);
      case (d)
         0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
         4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
         8: return 'h7F;  9: return 'h6F;  10: return 'h77; 11: return 'h7C;
         12: return 'h39; 13: return 'h5E; 14: return 'h79; default: return 'h71;
      endcase
   endfunction

   // Digit k of value v in base 10/16; blank when v has no digit at that position.
   function automatic int exp_seg(input int v, input bit hx, input int k);
      int base, p;
      base = hx ? 16 : 10;
      p = 1;
      for (int i = 0; i < k; i++) p = p * base;
      if (k > 0 && v < p) return 0;
      return glyph((v / p) % base);
   endfunction

   task automatic model_step();
      int l, ld_edge;
      l = {uio_in[7:3], ui_in[7:5]};
      ld_edge = (ui_in[2] && prev_ld == 0) ? 1 : 0;
      prev_ld = ui_in[2];
      for (int i = 0; i < 2; i++) begin
         int li;
         li = (l > max_c[i]) ? max_c[i] : l;
         wrp[i] = 0;
         if (ui_in[4]) begin
            cnt[i] = 0; ph[i] = 0;
         end else if (ld_edge != 0) begin
            cnt[i] = li; ph[i] = 0;
         end else if (ui_in[0] && ena) begin
            if (ph[i] == TD - 1) begin
               ph[i] = 0;
               if (!ui_in[1]) begin
                  if (cnt[i] == max_c[i]) begin cnt[i] = 0; wrp[i] = 1; end
                  else cnt[i]++;
               end else begin
                  if (cnt[i] == 0) begin cnt[i] = max_c[i]; wrp[i] = 1; end
                  else cnt[i]--;
               end
            end else begin
               ph[i]++;
            end
         end
      end
   endtask

   task automatic run_cycle();
      model_step();
      @(negedge clk);
      check_eq("wrap_a", uo[0][7], wrp[0]);
      check_eq("wrap_b", uo[1][7], wrp[1]);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic check_display(input string tag);
      int capv [2][ND];
      ui_in[0] = 1'b0;
      ui_in[4] = 1'b0;
      run_n(2 * (W + 2) + 2);
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < ND; k++) capv[i][k] = -1;
      for (int c = 0; c < ND * SD; c++) begin
         run_cycle();
         for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s_sel%0d", tag, i), 32'($onehot(uio[i])), 1);
            for (int k = 0; k < ND; k++)
               if (uio[i] == 8'(1 << k)) capv[i][k] = int'(uo[i][6:0]);
         end
      end
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < ND; k++)
            check_eq($sformatf("%s_inst%0d_dig%0d", tag, i, k), capv[i][k],
                     exp_seg(cnt[i], ui_in[3], k));
   endtask

   task automatic load(input logic [7:0] v, input bit hold);
      ui_in[7:5]  = v[2:0];
      uio_in[7:3] = v[7:3];
      uio_in[2:0] = 3'($urandom);
      ui_in[2]    = 1'b0;
      run_cycle();
      ui_in[2] = 1'b1;
      run_cycle();
      ui_in[2] = hold;
   endtask

   task automatic do_reset(input logic [7:0] ui_during);
      #2 rst_n = 1'b0;
      ui_in = ui_during;
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_uo", uo[i], 8'h00);
         check_eq("rst_uio", uio[i], 8'h00);
         check_eq("rst_oe", oe[i], 8'h07);
         cnt[i] = 0; ph[i] = 0; wrp[i] = 0;
      end
      prev_ld = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle();
      for (int i = 0; i < 2; i++) begin
         check_eq("first_sel", uio[i], 8'h01);
         check_eq("first_seg", uo[i][6:0], 7'h3F);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      prev_ld = 0;
      for (int i = 0; i < 2; i++) begin cnt[i] = 0; ph[i] = 0; wrp[i] = 0; end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_n(21);
      do_reset(8'h00);
      check_display("rst");

      load(8'hFF, 1'b0);
      check_display("l255");
      ui_in[1] = 1'b0; ui_in[0] = 1'b1;
      run_n(TD);
      check_display("wrap_up");
      ui_in[1] = 1'b1; ui_in[0] = 1'b1;
      run_n(TD);
      check_display("wrap_dn");

      ui_in[1] = 1'b0;
      load(8'd200, 1'b1);
      check_display("l200");
      ui_in[0] = 1'b1;
      run_n(3 * TD);
      check_display("hold_ld");
      ui_in[2] = 1'b0;
      load(8'd200, 1'b0);
      ui_in[3] = 1'b1;
      check_display("hex200");
      ui_in[3] = 1'b0;

      ui_in[7:5] = 3'd5; uio_in[7:3] = 5'd9;
      ui_in[4] = 1'b1; ui_in[2] = 1'b1;
      run_cycle();
      ui_in[4] = 1'b0; ui_in[2] = 1'b0;
      check_display("clr_ld");

      load(8'd50, 1'b0);
      ui_in[0] = 1'b1;
      for (int i = 0; i < TD && ph[0] != TD - 1; i++) run_cycle();
      ui_in[4] = 1'b1;
      run_cycle();
      ui_in[4] = 1'b0;
      check_display("tick_clr");

      load(8'd123, 1'b0);
      run_n(4);
      do_reset(8'h00);
      load(8'd77, 1'b0);
      check_display("post_rst");

      uio_in = 8'h00;
      do_reset(8'b1010_0100);
      ui_in[2] = 1'b0;
      check_display("ld_rst");

      ena = 1'b0;
      ui_in[0] = 1'b1;
      run_n(20);
      load(8'd42, 1'b0);
      check_display("ena_lo");
      ena = 1'b1;

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               ui_in[0] = 1'b1;
               ui_in[1] = 1'($urandom);
               ena = ($urandom_range(0, 3) != 0);
               run_n($urandom_range(1, 300));
               ena = 1'b1;
            end
            1: load(8'($urandom), 1'($urandom));
            2: begin
               ui_in[4] = 1'b1;
               ui_in[0] = 1'($urandom);
               run_cycle();
               ui_in[4] = 1'b0;
            end
            default: ui_in[3] = ~ui_in[3];
         endcase
         ui_in[2] = 1'b0;
         check_display($sformatf("rnd%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
